// File: rtl/period_meter_pkg.sv
// period_meter shared types.
// FSM state encoding for the period measurement control.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    HOLD
  } pm_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detector.
// Reusable for buttons and other asynchronous inputs.
module edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Resynchronize the input and keep one cycle of history.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures the spacing of rising edges on pulse_in in clock cycles.
// Results are offered on a valid/ready handshake.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int MAX = 50000000,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         pulse_in,
  input  logic         start,
  output logic         busy,
  output logic [W-1:0] period,
  output logic         overflow,
  output logic         valid,
  input  logic         ready
);

  localparam logic [W-1:0] MaxW = W'(MAX);
  localparam logic [W-1:0] One  = W'(1);

  pm_state_t    state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic         ovf_q, ovf_d;
  logic         edge_det;

  edge_sync u_sync (
    .clk_i  (CLOCK_50),
    .rst_ni (reset),
    .d_i    (pulse_in),
    .edge_o (edge_det)
  );

  // State, counter and result registers.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic; an edge wins over overflow.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ARMED;
      end
      ARMED: begin
        if (edge_det) begin
          cnt_d   = One;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          period_d = cnt_q;
          ovf_d    = 1'b0;
          state_d  = HOLD;
        end else if (cnt_q == MaxW) begin
          period_d = MaxW;
          ovf_d    = 1'b1;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      HOLD: begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == ARMED) ||
                    (state_q == MEASURE);
  assign valid    = (state_q == HOLD);
  assign period   = period_q;
  assign overflow = ovf_q;

endmodule
